sap_timing_gen: RTL and testbench
=================================

Name: sap_timing_gen

Overview:
Parametrised T-state ring counter and timing generator for the SAP-class CPU control unit. It drives a one-hot T-state vector to the controller/sequencer and adds the following on top of a plain ring:
- stepping enable
- early instruction termination
- sticky halt
- per-instruction done pulse
- retired-instruction counter

It sits between the clock/reset source and the control-word decoder.

Parameters:
NUM_STATES, 6, number of T-states per instruction cycle (min 2, max 16).
IDX_W, 3, width of binary state index; must satisfy 2**IDX_W >= NUM_STATES.
CNT_W, 8, width of retired-instruction counter.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  advance enable; when low the ring holds
end_early  input  1  with en: current state is the last of this instruction; next state is T1
hlt  input  1  halt request from decoder (HLT opcode)
count  output  NUM_STATES  one-hot T-state vector; bit 0 = T1
state_idx  output  IDX_W  binary index of active T-state (0 = T1)
instr_done  output  1  one-cycle pulse, high in the cycle after a return to T1
halted  output  1  sticky halt flag
instr_cnt  output  CNT_W  retired-instruction count, wraps
onehot_err  output  1  one-hot violation flag (see Optional Feature)

Behaviour:
- Reset (rst high at posedge) forces count = 1 (T1), state_idx = 0, instr_done = 0, halted = 0, instr_cnt = 0, onehot_err = 0. Reset overrides all other inputs, including mid-instruction and while halted.
- Priority per edge: rst > halted > (en & end_early) > en > hold.
- halted = 1: count, state_idx and instr_cnt are frozen. instr_done = 0. en, end_early and hlt are ignored. Only rst clears halted.
- hlt sampled high at posedge (not in reset): halted = 1 from the next cycle. The ring does not advance on that edge, so count freezes at the state where hlt was seen.
- en = 0: the ring holds and instr_done = 0. end_early is ignored without en.
- en = 1, end_early = 0:
  - count rotates left one bit; state_idx increments.
  - From T(NUM_STATES) the ring wraps to T1 and state_idx goes to 0.
- en = 1, end_early = 1: next state is T1 regardless of the current state. If already in T1, the ring stays in T1 and this counts as a completed instruction.
- Any edge that moves or keeps the ring at T1 via wrap or end_early:
  - instr_done = 1 for exactly the following cycle.
  - instr_cnt increments by 1 modulo 2**CNT_W.
- Latency: one clock from the input sample to the count/state_idx change. state_idx and count are always consistent, both registered in the same edge.
- No combinational path from inputs to outputs.
- Simultaneous hlt with en & end_early: halt wins; no advance, no instr_done, no count increment.

Optional Feature:
Macro: SAP_TIMING_ONEHOT_CHECK_EN.
- Defined: each cycle, if count is not exactly one-hot (zero or multiple bits), onehot_err is registered high for one cycle and the ring is forced to T1 (state_idx = 0) on the next edge. instr_cnt is unchanged; the recovery sets instr_done = 0 and holds it low.
- Not defined: the check logic is absent and onehot_err is tied to 0.
- The port exists in both builds.

Test Plan:
1. Reset then stepping: rst = 1 for 2 cycles, then rst = 0, en = 1 for 13 cycles -> count sequence 000001, 000010, ... 100000, 000001, ...; instr_done pulses after cycles 6 and 12; instr_cnt = 2.
2. Early end: en = 1; in T4 assert end_early for 1 cycle -> next count = 000001; instr_done = 1 one cycle; instr_cnt increments by 1; T5/T6 are skipped.
3. Enable gating: in T3, en = 0 for 5 cycles -> count stays 000100, state_idx = 2, instr_done = 0; on en = 1 it resumes to T4.
4. Halt: hlt = 1 in T5 -> halted = 1 next cycle; count frozen at 010000 for 20 cycles despite en = 1 and end_early = 1; then rst = 1 -> count = 000001, halted = 0, instr_cnt = 0.
5. Reset mid-instruction plus counter wrap: with CNT_W = 2, complete 5 instructions -> instr_cnt = 1; assert rst in T3 -> count = 000001 on the next edge; instr_cnt = 0.
6. With SAP_TIMING_ONEHOT_CHECK_EN: force count to 000101 via bench force/release -> onehot_err = 1 for one cycle, then count = 000001, instr_cnt unchanged. Without the macro, onehot_err stays 0.

Source files
------------

// File: rtl/sap_timing_if.sv
// Bundle between the SAP timing generator and the controller/sequencer:
// step controls in, one-hot T-state, halt and retire status out.
interface sap_timing_if #(
  parameter int NUM_STATES = 6,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 8
);
  logic                  en;
  logic                  end_early;
  logic                  hlt;
  logic [NUM_STATES-1:0] count;
  logic [IDX_W-1:0]      state_idx;
  logic                  instr_done;
  logic                  halted;
  logic [CNT_W-1:0]      instr_cnt;
  logic                  onehot_err;

  modport master (
    output en, end_early, hlt,
    input  count, state_idx, instr_done, halted, instr_cnt, onehot_err
  );

  modport slave (
    input  en, end_early, hlt,
    output count, state_idx, instr_done, halted, instr_cnt, onehot_err
  );
endinterface

// File: rtl/sap_timing_gen.sv
// T-state ring counter / timing generator for the SAP control unit.
// Define SAP_TIMING_ONEHOT_CHECK_EN to add one-hot checking and recovery to T1.
module sap_timing_gen #(
  parameter int NUM_STATES = 6,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  sap_timing_if.slave bus
);

  logic [NUM_STATES-1:0] ring_p1;
  logic [IDX_W-1:0]      idx_p1;
  logic                  done_p1;
  logic                  halt_p1;
  logic [CNT_W-1:0]      cnt_p1;
  logic                  retire;

  function automatic logic [NUM_STATES-1:0] rotl(input logic [NUM_STATES-1:0] r);
    return {r[NUM_STATES-2:0], r[NUM_STATES-1]};
  endfunction

`ifdef SAP_TIMING_ONEHOT_CHECK_EN
  function automatic logic is_onehot(input logic [NUM_STATES-1:0] r);
    return (r != '0) && ((r & (r - 1'b1)) == '0);
  endfunction
`endif

  // An instruction retires when the ring wraps from the last T-state or is cut short.
  assign retire = bus.end_early | ring_p1[NUM_STATES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_p1 <= NUM_STATES'(1);
      idx_p1  <= '0;
      done_p1 <= 1'b0;
      halt_p1 <= 1'b0;
      cnt_p1  <= '0;
    end
`ifdef SAP_TIMING_ONEHOT_CHECK_EN
    else if (!is_onehot(ring_p1)) begin
      ring_p1 <= NUM_STATES'(1);
      idx_p1  <= '0;
      done_p1 <= 1'b0;
    end
`endif
    else if (halt_p1) begin
      done_p1 <= 1'b0;
    end else if (bus.hlt) begin
      halt_p1 <= 1'b1;
      done_p1 <= 1'b0;
    end else if (bus.en) begin
      if (retire) begin
        ring_p1 <= NUM_STATES'(1);
        idx_p1  <= '0;
        done_p1 <= 1'b1;
        cnt_p1  <= cnt_p1 + CNT_W'(1);
      end else begin
        ring_p1 <= rotl(ring_p1);
        idx_p1  <= idx_p1 + IDX_W'(1);
        done_p1 <= 1'b0;
      end
    end else begin
      done_p1 <= 1'b0;
    end
  end

`ifdef SAP_TIMING_ONEHOT_CHECK_EN
  logic err_p1;

  always_ff @(posedge clk) begin
    if (rst) err_p1 <= 1'b0;
    else     err_p1 <= !is_onehot(ring_p1);
  end

  assign bus.onehot_err = err_p1;
`else
  assign bus.onehot_err = 1'b0;
`endif

  assign bus.count      = ring_p1;
  assign bus.state_idx  = idx_p1;
  assign bus.instr_done = done_p1;
  assign bus.halted     = halt_p1;
  assign bus.instr_cnt  = cnt_p1;

endmodule

// File: tb/tb_sap_timing_gen.sv
// Directed bench for sap_timing_gen (NUM_STATES=6, CNT_W=2 so counter wrap is reachable).
module tb_sap_timing_gen;

  localparam int NS = 6;
  localparam int IW = 3;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  sap_timing_if #(.NUM_STATES(NS), .IDX_W(IW), .CNT_W(CW)) bus ();

  sap_timing_gen #(.NUM_STATES(NS), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pos;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.end_early = 1'b0;
    bus.hlt = 1'b0;
    step();
    step();
    check("rst_count", 32'(bus.count), 32'h01);
    check("rst_idx", 32'(bus.state_idx), 0);
    check("rst_done", 32'(bus.instr_done), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_cnt", 32'(bus.instr_cnt), 0);
    check("rst_err", 32'(bus.onehot_err), 0);

    // Plain stepping for 13 edges
    rst = 1'b0;
    bus.en = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step();
      pos = i % NS;
      check($sformatf("step%0d_count", i), 32'(bus.count), 32'(1) << pos);
      check($sformatf("step%0d_idx", i), 32'(bus.state_idx), 32'(pos));
      check($sformatf("step%0d_done", i), 32'(bus.instr_done), (pos == 0) ? 1 : 0);
      check($sformatf("step%0d_cnt", i), 32'(bus.instr_cnt), 32'((i / NS) % 4));
    end
    check("step_cnt_final", 32'(bus.instr_cnt), 2);

    // Early end from T4
    step();
    step();
    check("t4_count", 32'(bus.count), 32'h08);
    bus.end_early = 1'b1;
    step();
    bus.end_early = 1'b0;
    check("early_count", 32'(bus.count), 32'h01);
    check("early_idx", 32'(bus.state_idx), 0);
    check("early_done", 32'(bus.instr_done), 1);
    check("early_cnt", 32'(bus.instr_cnt), 3);
    step();
    check("after_early_count", 32'(bus.count), 32'h02);
    check("after_early_done", 32'(bus.instr_done), 0);

    // Enable gating in T3
    step();
    check("t3_count", 32'(bus.count), 32'h04);
    bus.en = 1'b0;
    bus.end_early = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("gate_count", 32'(bus.count), 32'h04);
      check("gate_idx", 32'(bus.state_idx), 2);
      check("gate_done", 32'(bus.instr_done), 0);
    end
    bus.end_early = 1'b0;
    bus.en = 1'b1;
    step();
    check("resume_count", 32'(bus.count), 32'h08);
    check("resume_idx", 32'(bus.state_idx), 3);

    // Halt in T5, simultaneous with en & end_early
    step();
    check("t5_count", 32'(bus.count), 32'h10);
    bus.hlt = 1'b1;
    bus.end_early = 1'b1;
    step();
    bus.hlt = 1'b0;
    check("halt_flag", 32'(bus.halted), 1);
    check("halt_count", 32'(bus.count), 32'h10);
    check("halt_done", 32'(bus.instr_done), 0);
    check("halt_cnt", 32'(bus.instr_cnt), 3);
    for (int i = 0; i < 20; i++) begin
      step();
      check("frozen_count", 32'(bus.count), 32'h10);
      check("frozen_idx", 32'(bus.state_idx), 4);
      check("frozen_halted", 32'(bus.halted), 1);
      check("frozen_done", 32'(bus.instr_done), 0);
      check("frozen_cnt", 32'(bus.instr_cnt), 3);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.en = 1'b0;
    bus.end_early = 1'b0;
    check("unhalt_count", 32'(bus.count), 32'h01);
    check("unhalt_halted", 32'(bus.halted), 0);
    check("unhalt_cnt", 32'(bus.instr_cnt), 0);

    // end_early without en is ignored
    bus.end_early = 1'b1;
    step();
    check("noen_count", 32'(bus.count), 32'h01);
    check("noen_done", 32'(bus.instr_done), 0);
    check("noen_cnt", 32'(bus.instr_cnt), 0);

    // end_early while in T1 retires an instruction, then 4 full ones -> wrap to 1
    bus.en = 1'b1;
    step();
    bus.end_early = 1'b0;
    check("t1_early_count", 32'(bus.count), 32'h01);
    check("t1_early_done", 32'(bus.instr_done), 1);
    check("t1_early_cnt", 32'(bus.instr_cnt), 1);
    for (int i = 0; i < 4 * NS; i++) step();
    check("wrap_count", 32'(bus.count), 32'h01);
    check("wrap_done", 32'(bus.instr_done), 1);
    check("wrap_cnt", 32'(bus.instr_cnt), 1);
    step();
    step();
    check("mid_t3_count", 32'(bus.count), 32'h04);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.en = 1'b0;
    check("midrst_count", 32'(bus.count), 32'h01);
    check("midrst_idx", 32'(bus.state_idx), 0);
    check("midrst_cnt", 32'(bus.instr_cnt), 0);
    check("midrst_done", 32'(bus.instr_done), 0);

`ifdef SAP_TIMING_ONEHOT_CHECK_EN
    // Corrupt the ring and expect recovery to T1
    bus.en = 1'b1;
    step();
    step();
    bus.en = 1'b0;
    check("pre_corrupt_cnt", 32'(bus.instr_cnt), 0);
    @(negedge clk);
    force dut.ring_p1 = 6'b000101;
    #1;
    release dut.ring_p1;
    step();
    check("oh_err", 32'(bus.onehot_err), 1);
    check("oh_count", 32'(bus.count), 32'h01);
    check("oh_idx", 32'(bus.state_idx), 0);
    check("oh_done", 32'(bus.instr_done), 0);
    check("oh_cnt", 32'(bus.instr_cnt), 0);
    step();
    check("oh_err_clear", 32'(bus.onehot_err), 0);
    check("oh_count_hold", 32'(bus.count), 32'h01);
`else
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_oh_err", 32'(bus.onehot_err), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
